// File: rtl/br_resolve_pkg.sv
// rtl/br_resolve_pkg.sv - shared address width, default queue depth and FSM state encoding for br_resolve
package br_resolve_pkg;

    localparam int INST_ADDR_BUS  = 32;
    localparam int PRED_DEPTH_DEF = 4;
    localparam int INST_BYTES     = 4;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/br_resolve_pred_fifo.sv
// rtl/br_resolve_pred_fifo.sv - circular prediction buffer with push/pop/clear and registered occupancy
module br_resolve_pred_fifo
    import br_resolve_pkg::*;
#(
    parameter int DEPTH = PRED_DEPTH_DEF,
    parameter int W     = 2 * INST_ADDR_BUS + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (PW+1)'(1);
                2'b01:   count_d = count_q - (PW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/br_resolve.sv
// rtl/br_resolve.sv - branch prediction checker: queues IF predictions, checks them at EX, trains and flushes
// Optional statistics counters (stat_br/stat_miss) are built when BR_STATS_EN is defined.
module br_resolve
    import br_resolve_pkg::*;
#(
    parameter int DEPTH  = PRED_DEPTH_DEF,
    parameter int ADDR_W = INST_ADDR_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic              if_br_p,
    input  logic [ADDR_W-1:0] if_addr_p,
    output logic              q_full,
    output logic              q_empty,
    input  logic              ex_valid,
    input  logic              ex_is_br,
    input  logic              ex_jmp,
    input  logic [ADDR_W-1:0] ex_jmp_addr,
    output logic              upd_is_br,
    output logic [ADDR_W-1:0] upd_addr,
    output logic [ADDR_W-1:0] upd_jmp_addr,
    output logic              upd_jmp,
`ifdef BR_STATS_EN
    output logic [31:0]       stat_br,
    output logic [31:0]       stat_miss,
`endif
    output logic              flush,
    output logic [ADDR_W-1:0] redirect_pc
);

    localparam int EW = 2 * ADDR_W + 1;

    state_e            state_q, state_d;
    logic              run;
    logic              do_push, do_pop, mispredict, miss;
    logic [EW-1:0]     head;
    logic [ADDR_W-1:0] head_pc, head_addr_p, redirect_d;
    logic              head_br_p;

    logic              upd_is_br_q;
    logic [ADDR_W-1:0] upd_addr_q, upd_jmp_addr_q, redirect_q;
    logic              upd_jmp_q;

    assign run     = (state_q == ST_RUN);
    assign do_pop  = run && ex_valid && !q_empty;
    assign do_push = run && if_valid && (!q_full || do_pop);

    br_resolve_pred_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .clear (miss),
        .wdata ({if_pc, if_br_p, if_addr_p}),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    assign {head_pc, head_br_p, head_addr_p} = head;

    // Non-branches that hit in the BTB are treated like not-taken branches
    always_comb begin
        mispredict = head_br_p;
        redirect_d = head_pc + ADDR_W'(INST_BYTES);
        if (ex_is_br && ex_jmp) begin
            mispredict = !head_br_p || (head_addr_p != ex_jmp_addr);
            redirect_d = ex_jmp_addr;
        end
    end

    assign miss = do_pop && mispredict;

    always_comb begin
        state_d = state_q;
        flush   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (miss) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                flush   = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            redirect_q     <= '0;
            upd_is_br_q    <= 1'b0;
            upd_addr_q     <= '0;
            upd_jmp_addr_q <= '0;
            upd_jmp_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            upd_is_br_q <= do_pop && ex_is_br;
            if (miss) redirect_q <= redirect_d;
            if (do_pop && ex_is_br) begin
                upd_addr_q     <= head_pc;
                upd_jmp_addr_q <= ex_jmp_addr;
                upd_jmp_q      <= ex_jmp;
            end
        end
    end

    assign upd_is_br    = upd_is_br_q;
    assign upd_addr     = upd_addr_q;
    assign upd_jmp_addr = upd_jmp_addr_q;
    assign upd_jmp      = upd_jmp_q;
    assign redirect_pc  = redirect_q;

`ifdef BR_STATS_EN
    logic [31:0] stat_br_q, stat_miss_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_br_q   <= '0;
            stat_miss_q <= '0;
        end else begin
            if (do_pop && ex_is_br) stat_br_q <= stat_br_q + 32'd1;
            if (miss) stat_miss_q <= stat_miss_q + 32'd1;
        end
    end

    assign stat_br   = stat_br_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// tb/tb_br_resolve.sv - directed bench with a queue-based reference model for br_resolve
module tb_br_resolve;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0, if_br_p = 1'b0;
    logic [31:0] if_pc = '0, if_addr_p = '0;
    logic        ex_valid = 1'b0, ex_is_br = 1'b0, ex_jmp = 1'b0;
    logic [31:0] ex_jmp_addr = '0;
    logic        q_full, q_empty, upd_is_br, upd_jmp, flush;
    logic [31:0] upd_addr, upd_jmp_addr, redirect_pc;
`ifdef BR_STATS_EN
    logic [31:0] stat_br, stat_miss;
`endif

    br_resolve #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_br_p      (if_br_p),
        .if_addr_p    (if_addr_p),
        .q_full       (q_full),
        .q_empty      (q_empty),
        .ex_valid     (ex_valid),
        .ex_is_br     (ex_is_br),
        .ex_jmp       (ex_jmp),
        .ex_jmp_addr  (ex_jmp_addr),
        .upd_is_br    (upd_is_br),
        .upd_addr     (upd_addr),
        .upd_jmp_addr (upd_jmp_addr),
        .upd_jmp      (upd_jmp),
`ifdef BR_STATS_EN
        .stat_br      (stat_br),
        .stat_miss    (stat_miss),
`endif
        .flush        (flush),
        .redirect_pc  (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the in-flight predictions as a plain queue
    typedef struct {
        logic [31:0] pc;
        logic        br_p;
        logic [31:0] addr_p;
    } pred_t;

    pred_t       pq[$];
    bit          m_flush;
    logic [31:0] m_redirect, m_upd_addr, m_upd_jmp_addr;
    bit          m_upd_is_br, m_upd_jmp;
    int unsigned m_br, m_miss;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pq.delete();
            m_flush = 0; m_redirect = '0; m_upd_is_br = 0;
            m_upd_addr = '0; m_upd_jmp_addr = '0; m_upd_jmp = 0;
            m_br = 0; m_miss = 0;
        end else if (m_flush) begin
            m_flush = 0;
            m_upd_is_br = 0;
        end else begin
            bit    pop, push, taken, wrong;
            pred_t e;
            pop  = ex_valid && (pq.size() > 0);
            push = if_valid && ((pq.size() < DEPTH) || pop);
            m_upd_is_br = 0;
            wrong = 0;
            if (pop) begin
                e = pq.pop_front();
                taken = ex_is_br && ex_jmp;
                wrong = (e.br_p != taken) || (taken && e.addr_p != ex_jmp_addr);
                if (ex_is_br) begin
                    m_upd_is_br = 1; m_upd_addr = e.pc;
                    m_upd_jmp = ex_jmp; m_upd_jmp_addr = ex_jmp_addr;
                    m_br++;
                end
                if (wrong) begin
                    m_miss++;
                    m_flush = 1;
                    m_redirect = taken ? ex_jmp_addr : e.pc + 32'd4;
                    pq.delete();
                end
            end
            if (push && !wrong) pq.push_back('{if_pc, if_br_p, if_addr_p});
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("q_full",       32'(q_full),      32'(pq.size() == DEPTH));
            chk("q_empty",      32'(q_empty),     32'(pq.size() == 0));
            chk("flush",        32'(flush),       32'(m_flush));
            chk("redirect_pc",  redirect_pc,      m_redirect);
            chk("upd_is_br",    32'(upd_is_br),   32'(m_upd_is_br));
            chk("upd_addr",     upd_addr,         m_upd_addr);
            chk("upd_jmp",      32'(upd_jmp),     32'(m_upd_jmp));
            chk("upd_jmp_addr", upd_jmp_addr,     m_upd_jmp_addr);
`ifdef BR_STATS_EN
            chk("stat_br",      stat_br,          m_br);
            chk("stat_miss",    stat_miss,        m_miss);
`endif
        end
    end

    task automatic drive(input logic iv, input logic [31:0] pc, input logic bp, input logic [31:0] ap,
                         input logic ev, input logic ib, input logic j, input logic [31:0] ja);
        if_valid = iv; if_pc = pc; if_br_p = bp; if_addr_p = ap;
        ex_valid = ev; ex_is_br = ib; ex_jmp = j; ex_jmp_addr = ja;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic bp, input logic [31:0] ap);
        drive(1, pc, bp, ap, 0, 0, 0, 0);
    endtask

    task automatic pop(input logic ib, input logic j, input logic [31:0] ja);
        drive(0, 0, 0, 0, 1, ib, j, ja);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst q_empty", 32'(q_empty), 32'd1);
        chk("rst q_full",  32'(q_full),  32'd0);
        chk("rst flush",   32'(flush),   32'd0);
        chk("rst upd",     32'(upd_is_br), 32'd0);
        chk("rst redir",   redirect_pc,  32'd0);
        #1 rst = 1'b1;
        idle();

        // Correctly predicted taken branch trains, no flush
        push(32'h100, 1, 32'h200);
        pop(1, 1, 32'h200);
        chk("s1 upd_is_br", 32'(upd_is_br), 32'd1);
        chk("s1 upd_addr",  upd_addr,       32'h100);
        chk("s1 upd_jmp",   32'(upd_jmp),   32'd1);
        chk("s1 flush",     32'(flush),     32'd0);
        idle();

        // Predicted taken, actually not taken
        push(32'h104, 1, 32'h300);
        pop(1, 0, 32'h0);
        chk("s2 flush",   32'(flush),   32'd1);
        chk("s2 redir",   redirect_pc,  32'h108);
        chk("s2 upd_jmp", 32'(upd_jmp), 32'd0);
        chk("s2 empty",   32'(q_empty), 32'd1);
        idle();
        chk("s2 unflush", 32'(flush), 32'd0);

        // Predicted not taken but taken; then predicted taken to a wrong target
        push(32'h10, 0, 32'h0);
        pop(1, 1, 32'h40);
        chk("s3a flush", 32'(flush), 32'd1);
        chk("s3a redir", redirect_pc, 32'h40);
        idle();
        push(32'h10, 1, 32'h44);
        pop(1, 1, 32'h40);
        chk("s3b flush", 32'(flush), 32'd1);
        chk("s3b redir", redirect_pc, 32'h40);
        idle();

        // Fill, drop an overflow push, push+pop while full, then drain in order
        for (int i = 0; i < DEPTH; i++) push(32'h1000 + 32'(4 * i), 0, 32'h0);
        chk("s4 full", 32'(q_full), 32'd1);
        push(32'h2000, 0, 32'h0);
        chk("s4 drop full", 32'(q_full), 32'd1);
        drive(1, 32'h1010, 0, 32'h0, 1, 1, 0, 32'h0);
        chk("s4 pp full", 32'(q_full), 32'd1);
        chk("s4 pp addr", upd_addr, 32'h1000);
        for (int i = 1; i <= DEPTH; i++) begin
            pop(1, 0, 32'h0);
            chk("s4 order", upd_addr, 32'h1000 + 32'(4 * i));
        end
        chk("s4 empty", 32'(q_empty), 32'd1);
        chk("s4 noflush", 32'(flush), 32'd0);

        // Aliased non-branch with a concurrent push; IF/EX ignored during FLUSH
        push(32'h20, 1, 32'h80);
        drive(1, 32'h30, 0, 32'h0, 1, 0, 0, 32'h0);
        chk("s5 flush", 32'(flush), 32'd1);
        chk("s5 redir", redirect_pc, 32'h24);
        chk("s5 upd",   32'(upd_is_br), 32'd0);
        chk("s5 empty", 32'(q_empty), 32'd1);
        drive(1, 32'h34, 0, 32'h0, 1, 1, 0, 32'h0);
        chk("s5 ign empty", 32'(q_empty), 32'd1);
        chk("s5 ign flush", 32'(flush), 32'd0);
        chk("s5 ign upd",   32'(upd_is_br), 32'd0);
        idle();
`ifdef BR_STATS_EN
        chk("stat_br lit",   stat_br,   32'd9);
        chk("stat_miss lit", stat_miss, 32'd4);
`endif

        // Reset asserted in the middle of FLUSH
        push(32'h50, 1, 32'h90);
        pop(1, 0, 32'h0);
        chk("s6 flush", 32'(flush), 32'd1);
        rst = 1'b0;
        #1;
        chk("s6 rst flush", 32'(flush), 32'd0);
        chk("s6 rst redir", redirect_pc, 32'd0);
        chk("s6 rst upd",   32'(upd_is_br), 32'd0);
        chk("s6 rst uaddr", upd_addr, 32'd0);
        chk("s6 rst empty", 32'(q_empty), 32'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        idle();
        push(32'h60, 0, 32'h0);
        pop(0, 0, 32'h0);
        chk("s7 post flush", 32'(flush), 32'd0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- Consumer and checker of branch predictions. Sits between IF/pc_reg and EX.
- Holds every fetched instruction's prediction (pc, predicted-taken, predicted target) in an in-order queue.
- When EX resolves the instruction, compares the stored prediction with the actual outcome.
- Drives the predictor's training port (is_br/addr_ex/jmp_addr/jmp) and the pipeline flush/redirect.

Parameters:
DEPTH, 4, prediction queue entries (power of 2, ≥2)
ADDR_W, 32, instruction address width (matches InstAddrBus)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
if_valid  in  1  push: instruction fetched this cycle
if_pc  in  ADDR_W  fetched pc
if_br_p  in  1  predicted taken
if_addr_p  in  ADDR_W  predicted target
q_full  out  1  queue full; IF stalls
q_empty  out  1  queue empty
ex_valid  in  1  pop: EX resolves the oldest instruction
ex_is_br  in  1  instruction is a branch/jal/jalr
ex_jmp  in  1  actually taken
ex_jmp_addr  in  ADDR_W  actual target
upd_is_br  out  1  predictor train strobe
upd_addr  out  ADDR_W  pc of trained branch
upd_jmp_addr  out  ADDR_W  actual target
upd_jmp  out  1  actual taken
flush  out  1  one-cycle pipeline flush
redirect_pc  out  ADDR_W  correct next pc, valid while flush=1

Behaviour:
- Reset (rst=0, async): queue emptied (rd_ptr=wr_ptr=count=0), state RUN, all outputs 0 except q_empty=1.
- Queue: count 0..DEPTH; q_full=(count==DEPTH) and q_empty=(count==0), both from registers. Pointers wrap modulo DEPTH.
- Push if if_valid && (!q_full || pop same cycle); a push while full with no pop is dropped.
- Pop if ex_valid && !q_empty. ex_valid on an empty queue is ignored: no update, no flush.
- Simultaneous push and pop: count unchanged.
- Check on pop, using head entry {pc, br_p, addr_p}:
  - Branch, actually taken: mispredict if !br_p or addr_p!=ex_jmp_addr; redirect=ex_jmp_addr.
  - Branch, not taken: mispredict if br_p; redirect=pc+4 (mod 2^ADDR_W).
  - Not a branch (aliased BTB hit): mispredict if br_p; redirect=pc+4.
- Training: upd_* registered, valid the cycle after a pop with ex_is_br=1. upd_is_br is a 1-cycle pulse, with upd_addr=head pc, upd_jmp=ex_jmp, upd_jmp_addr=ex_jmp_addr. Training is issued for correct and mispredicted branches alike; non-branches never train.
- FSM RUN:
  - Mispredict in cycle N: at the N/N+1 edge the queue is cleared (including any push in cycle N), state→FLUSH, redirect_pc is loaded.
- FSM FLUSH (exactly 1 cycle, N+1):
  - flush=1; if_valid and ex_valid are ignored; next state RUN, flush returns to 0.
- Flush latency: exactly 1 cycle from the mispredicting pop.
- Reset mid-FLUSH: flush drops immediately (asynchronously).
- redirect_pc holds its last value outside FLUSH.

Optional Feature:
BR_STATS_EN:
- With the macro: adds outputs stat_br (32) and stat_miss (32). stat_br increments on each branch pop; stat_miss on each mispredict, including non-branch aliasing. Both wrap at 2^32 and reset to 0.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- defines.v holds InstAddrBus, the RUN/FLUSH state encodings, and the default queue depth.
- One natural sub-module, pred_fifo: parameterised circular buffer with push/pop/clear and full/empty.
- Compare logic, FSM and training registers live in br_resolve.

Test Plan:
- Reset then push pc=0x100 (br_p=1, addr_p=0x200), pop with ex_is_br=1, jmp=1, jmp_addr=0x200 → next cycle upd_is_br=1, upd_addr=0x100, upd_jmp=1; flush stays 0.
- Push pc=0x104 (br_p=1, addr_p=0x300), pop with ex_is_br=1, jmp=0 → next cycle flush=1, redirect_pc=0x108, upd_jmp=0; queue empty; then flush=0.
- Push pc=0x10 (br_p=0), pop with jmp=1, jmp_addr=0x40 → flush=1, redirect_pc=0x40. Predicted-taken with wrong target 0x44 → same redirect 0x40.
- Fill 4 entries → q_full=1; extra push alone is dropped (count stays 4). Push+pop in the same cycle → count stays 4 and entry order is preserved across the pointer wrap.
- Non-branch pop with br_p=1 at pc=0x20 → flush, redirect_pc=0x24, upd_is_br stays 0. Push in the mispredict cycle is discarded and q_empty=1 during FLUSH.
- Assert rst=0 during FLUSH → flush=0 immediately and all outputs 0. With BR_STATS_EN: after the scenarios above, stat_br and stat_miss equal the counts scored by the scoreboard.
